// File: rtl/cpu_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int          PC_W_DEFAULT = 64;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // ready to issue a fetch
    WAIT = 2'd1,  // one fetch outstanding, response will be used
    KILL = 2'd2,  // one fetch outstanding, response will be discarded
    HOLD = 2'd3   // response parked in the skid buffer while ID is stalled
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response bundle between fetch and imem.
// Latency: response at least one cycle after its request.
// Backpressure: none; fetch keeps at most one request outstanding.
interface instr_fetch_if #(
  parameter int PC_W = 64
);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_rvalid;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch_if_id_reg.sv
// IF/ID pipeline register: PC, instruction word and valid flag for decode.
// Latency: 1 cycle from load to outputs.
// Backpressure: stall holds all fields; flush wins over stall and loads a NOP bubble.
import cpu_pkg::*;

module if_id_reg #(
  parameter int PC_W = PC_W_DEFAULT
) (
  input  logic            clk,
  input  logic            arst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic            load,
  input  logic [PC_W-1:0] load_pc,
  input  logic [31:0]     load_instr,
  output logic [PC_W-1:0] pc,
  output logic [31:0]     instr,
  output logic            valid
);

  // Priority: reset, flush, stall (hold), load, otherwise insert a bubble.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      pc    <= '0;
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (flush) begin
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (stall) begin
      pc    <= pc;
      instr <= instr;
      valid <= valid;
    end else if (load) begin
      pc    <= load_pc;
      instr <= load_instr;
      valid <= 1'b1;
    end else begin
      // Bubble keeps the old PC so debug views still show where fetch was.
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: owns the PC, issues single-outstanding imem fetches, feeds IF/ID.
// Latency: request at cycle t reaches IF/ID at edge t+2 with a 1-cycle imem; 1 instr/cycle.
// Backpressure: stall holds IF/ID and PC; a response arriving under stall is parked in a skid buffer.
import cpu_pkg::*;

module instr_fetch #(
  parameter int              PC_W     = PC_W_DEFAULT,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 arst_n,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [PC_W-1:0]      redirect_pc,
  instr_fetch_if.master        imem,
  output logic [PC_W-1:0]      if_id_pc,
  output logic [31:0]          if_id_instr,
  output logic                 if_id_valid
);

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_pc_nxt;
  logic [PC_W-1:0] w_pc_plus4;
  logic [PC_W-1:0] w_redir_pc;
  logic [PC_W-1:0] r_skid_pc;
  logic [31:0]     r_skid_instr;
  logic            w_skid_load;
  logic            w_req;
  logic [PC_W-1:0] w_addr;
  logic            w_deliver;
  logic [PC_W-1:0] w_deliver_pc;
  logic [31:0]     w_deliver_instr;

  // Targets are word aligned; the low two bits of a redirect are discarded.
  assign w_redir_pc = redirect_pc & ~{{(PC_W-2){1'b0}}, 2'b11};
  // Wraps modulo 2^PC_W without any special handling.
  assign w_pc_plus4 = r_pc + PC_W'(4);

  // State, PC and skid buffer registers.
  always_ff @(posedge clk) begin
    if (!arst_n) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_skid_pc    <= '0;
      r_skid_instr <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_skid_load) begin
        r_skid_pc    <= r_pc;
        r_skid_instr <= imem.imem_rdata;
      end
    end
  end

  // Next state, next PC, request and IF/ID delivery; redirect > stall > normal flow.
  always_comb begin
    w_state_nxt     = r_state;
    w_pc_nxt        = r_pc;
    w_req           = 1'b0;
    w_addr          = r_pc;
    w_skid_load     = 1'b0;
    w_deliver       = 1'b0;
    w_deliver_pc    = r_pc;
    w_deliver_instr = imem.imem_rdata;
    unique case (r_state)
      IDLE: begin
        // A stray rvalid here is a protocol violation and is ignored.
        if (redirect) begin
          w_pc_nxt = w_redir_pc;
        end else begin
          w_req       = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (imem.imem_rvalid) begin
          if (redirect) begin
            w_pc_nxt    = w_redir_pc;
            w_state_nxt = IDLE;
          end else if (stall) begin
            w_skid_load = 1'b1;
            w_state_nxt = HOLD;
          end else begin
            // Deliver and immediately fetch the next word for full throughput.
            w_deliver   = 1'b1;
            w_pc_nxt    = w_pc_plus4;
            w_req       = 1'b1;
            w_addr      = w_pc_plus4;
          end
        end else if (redirect) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = KILL;
        end
      end
      KILL: begin
        if (redirect) begin
          w_pc_nxt = w_redir_pc;
        end
        if (imem.imem_rvalid) begin
          w_state_nxt = IDLE;
        end
      end
      HOLD: begin
        if (redirect) begin
          w_pc_nxt    = w_redir_pc;
          w_state_nxt = IDLE;
        end else if (!stall) begin
          w_deliver       = 1'b1;
          w_deliver_pc    = r_skid_pc;
          w_deliver_instr = r_skid_instr;
          w_pc_nxt        = w_pc_plus4;
          w_state_nxt     = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // No fetch leaves the stage while reset is asserted.
  assign imem.imem_req  = w_req & arst_n;
  assign imem.imem_addr = w_addr;

  if_id_reg #(
    .PC_W (PC_W)
  ) u_if_id_reg (
    .clk        (clk),
    .arst_n     (arst_n),
    .stall      (stall),
    .flush      (redirect),
    .load       (w_deliver),
    .load_pc    (w_deliver_pc),
    .load_instr (w_deliver_instr),
    .pc         (if_id_pc),
    .instr      (if_id_instr),
    .valid      (if_id_valid)
  );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: stream, stall/skid, redirects, wrap, mid-fetch reset.
// Latency: n/a.
// Backpressure: n/a.
import cpu_pkg::*;

module tb_instr_fetch;

  localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

  logic        clk;
  logic        arst_n;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic [63:0] if_id_pc;
  logic [31:0] if_id_instr;
  logic        if_id_valid;
  logic [63:0] w_if_id_pc;
  logic [31:0] w_if_id_instr;
  logic        w_if_id_valid;

  int n_cmp = 0;
  int n_err = 0;
  int lat   = 1;

  instr_fetch_if #(.PC_W(64)) bus ();
  instr_fetch_if #(.PC_W(64)) wbus ();

  instr_fetch #(.PC_W(64), .RESET_PC(64'h0)) u_dut (
    .clk         (clk),
    .arst_n      (arst_n),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem        (bus.master),
    .if_id_pc    (if_id_pc),
    .if_id_instr (if_id_instr),
    .if_id_valid (if_id_valid)
  );

  instr_fetch #(.PC_W(64), .RESET_PC(WRAP_PC)) u_wrap (
    .clk         (clk),
    .arst_n      (arst_n),
    .stall       (1'b0),
    .redirect    (1'b0),
    .redirect_pc (64'h0),
    .imem        (wbus.master),
    .if_id_pc    (w_if_id_pc),
    .if_id_instr (w_if_id_instr),
    .if_id_valid (w_if_id_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] tag(input logic [63:0] a);
    return {8'hA5, a[23:0]};
  endfunction

  // Instruction memory with programmable latency (in cycles) for the main DUT.
  logic        m_rvalid = 1'b0;
  logic [31:0] m_rdata  = '0;
  logic [63:0] m_addr   = '0;
  int          m_cnt    = 0;
  always @(posedge clk) begin
    m_rvalid <= 1'b0;
    if (m_cnt > 1) begin
      m_cnt <= m_cnt - 1;
    end else if (m_cnt == 1) begin
      m_rvalid <= 1'b1;
      m_rdata  <= tag(m_addr);
      m_cnt    <= 0;
    end
    if (bus.imem_req) begin
      if (lat == 1) begin
        m_rvalid <= 1'b1;
        m_rdata  <= tag(bus.imem_addr);
      end else begin
        m_addr <= bus.imem_addr;
        m_cnt  <= lat - 1;
      end
    end
  end
  assign bus.imem_rvalid = m_rvalid;
  assign bus.imem_rdata  = m_rdata;

  // Fixed 1-cycle memory for the wrap-around instance.
  logic        wm_rvalid = 1'b0;
  logic [31:0] wm_rdata  = '0;
  always @(posedge clk) begin
    wm_rvalid <= wbus.imem_req;
    wm_rdata  <= tag(wbus.imem_addr);
  end
  assign wbus.imem_rvalid = wm_rvalid;
  assign wbus.imem_rdata  = wm_rdata;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    arst_n      = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", 64'(if_id_valid), 64'h0);
    chk("rst_instr", 64'(if_id_instr), 64'(NOP_INSTR));
    chk("rst_pc",    if_id_pc,         64'h0);
    chk("rst_req",   64'(bus.imem_req), 64'h0);
    chk("rst_wreq",  64'(wbus.imem_req), 64'h0);

    // Release: first request in the first cycle out of reset
    arst_n = 1'b1;
    #1;
    chk("c0_req",   64'(bus.imem_req), 64'h1);
    chk("c0_addr",  bus.imem_addr,     64'h0);
    chk("w0_addr",  wbus.imem_addr,    WRAP_PC);

    nxt(); #1;
    chk("c1_req",   64'(bus.imem_req), 64'h1);
    chk("c1_addr",  bus.imem_addr,     64'h4);
    chk("c1_valid", 64'(if_id_valid),  64'h0);
    chk("w1_req",   64'(wbus.imem_req), 64'h1);
    chk("w1_addr",  wbus.imem_addr,    64'h0);

    nxt(); #1;
    chk("c2_pc",    if_id_pc,          64'h0);
    chk("c2_valid", 64'(if_id_valid),  64'h1);
    chk("c2_instr", 64'(if_id_instr),  64'(tag(64'h0)));
    chk("c2_addr",  bus.imem_addr,     64'h8);
    chk("w2_pc",    w_if_id_pc,        WRAP_PC);

    nxt(); #1;
    chk("c3_pc",    if_id_pc,          64'h4);
    chk("c3_addr",  bus.imem_addr,     64'hC);
    chk("w3_pc",    w_if_id_pc,        64'h0);
    chk("w3_valid", 64'(w_if_id_valid), 64'h1);

    nxt(); #1;
    chk("c4_pc",    if_id_pc,          64'h8);
    chk("c4_addr",  bus.imem_addr,     64'h10);

    // Stall while the 0x10 response arrives
    nxt(); stall = 1'b1; #1;
    chk("s0_req",   64'(bus.imem_req), 64'h0);
    chk("s0_pc",    if_id_pc,          64'hC);

    nxt(); #1;
    chk("s1_req",   64'(bus.imem_req), 64'h0);
    chk("s1_pc",    if_id_pc,          64'hC);
    chk("s1_valid", 64'(if_id_valid),  64'h1);
    chk("s1_state", 64'(u_dut.r_state), 64'(HOLD));

    nxt(); #1;
    chk("s2_req",   64'(bus.imem_req), 64'h0);

    nxt(); stall = 1'b0; #1;
    chk("s3_req",   64'(bus.imem_req), 64'h0);
    chk("s3_pc",    if_id_pc,          64'hC);

    nxt(); #1;
    chk("s4_pc",    if_id_pc,          64'h10);
    chk("s4_instr", 64'(if_id_instr),  64'(tag(64'h10)));
    chk("s4_valid", 64'(if_id_valid),  64'h1);
    chk("s4_req",   64'(bus.imem_req), 64'h1);
    chk("s4_addr",  bus.imem_addr,     64'h14);

    // Redirect together with stall, unaligned target
    stall = 1'b1; redirect = 1'b1; redirect_pc = 64'h203; #1;
    chk("rs_req",   64'(bus.imem_req), 64'h0);

    nxt(); stall = 1'b0; redirect = 1'b0; lat = 3; #1;
    chk("rs_valid", 64'(if_id_valid),  64'h0);
    chk("rs_instr", 64'(if_id_instr),  64'(NOP_INSTR));
    chk("rs_pc",    if_id_pc,          64'h10);
    chk("rs_req1",  64'(bus.imem_req), 64'h1);
    chk("rs_addr",  bus.imem_addr,     64'h200);

    // Redirect one cycle after the request, 3-cycle imem
    nxt(); redirect = 1'b1; redirect_pc = 64'h100; #1;
    chk("rw_req0",  64'(bus.imem_req), 64'h0);

    nxt(); redirect = 1'b0; #1;
    chk("rw_req1",  64'(bus.imem_req), 64'h0);
    chk("rw_state", 64'(u_dut.r_state), 64'(KILL));

    nxt(); lat = 1; #1;
    chk("rw_req2",  64'(bus.imem_req), 64'h0);
    chk("rw_valid", 64'(if_id_valid),  64'h0);

    nxt(); #1;
    chk("rw_req3",  64'(bus.imem_req), 64'h1);
    chk("rw_addr",  bus.imem_addr,     64'h100);
    chk("rw_drop",  64'(if_id_valid),  64'h0);
    chk("rw_nop",   64'(if_id_instr),  64'(NOP_INSTR));

    nxt(); lat = 3; #1;
    chk("rw_addr2", bus.imem_addr,     64'h104);

    nxt(); #1;
    chk("rw_pc",    if_id_pc,          64'h100);
    chk("rw_instr", 64'(if_id_instr),  64'(tag(64'h100)));
    chk("rw_req4",  64'(bus.imem_req), 64'h0);

    // Reset while a 3-cycle fetch is in flight
    arst_n = 1'b0;
    nxt(); #1;
    chk("mr_valid", 64'(if_id_valid),  64'h0);
    chk("mr_instr", 64'(if_id_instr),  64'(NOP_INSTR));
    chk("mr_pc",    if_id_pc,          64'h0);
    chk("mr_req",   64'(bus.imem_req), 64'h0);

    nxt(); #1;
    chk("mr_req2",  64'(bus.imem_req), 64'h0);
    arst_n = 1'b1; #1;
    chk("mr_req3",  64'(bus.imem_req), 64'h1);
    chk("mr_addr",  bus.imem_addr,     64'h0);
    chk("mr_state", 64'(u_dut.r_state), 64'(IDLE));

    nxt(); #1;
    chk("mr_state2", 64'(u_dut.r_state), 64'(WAIT));
    chk("mr_valid2", 64'(if_id_valid),  64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
